// File: rtl/issue_dispatch_pkg.sv
// Shared types for the issue buffer: FU selector, FU ready vector, op bundle.
// Also sets the default issue-queue depth used by the instantiating parent.
package issue_dispatch_pkg;

    localparam int NUM_FU        = 4;
    localparam int ISSUE_Q_DEPTH = 4;

    typedef enum logic [1:0] {
        FU_ALU = 2'd0,
        FU_MUL = 2'd1,
        FU_LSU = 2'd2,
        FU_BR  = 2'd3
    } fu_t;

    typedef logic [NUM_FU-1:0] fu_bitvector_t;

    typedef struct packed {
        fu_t         fu;
        logic [5:0]  id;
        logic [31:0] imm;
    } fu_input_t;

endpackage

// File: rtl/issue_dispatch_if.sv
// Upstream op handshake plus FU-cluster head/ready bundle.
// master = upstream and FU cluster side, slave = issue_dispatch.
interface issue_dispatch_if;
    import issue_dispatch_pkg::*;

    fu_input_t     op_i;
    logic          op_i_valid;
    logic          op_i_ready;
    fu_input_t     fuinput_o;
    logic          fuinput_o_valid;
    fu_bitvector_t fuinput_o_ready;

    modport master (
        output op_i,
        output op_i_valid,
        input  op_i_ready,
        input  fuinput_o,
        input  fuinput_o_valid,
        output fuinput_o_ready
    );

    modport slave (
        input  op_i,
        input  op_i_valid,
        output op_i_ready,
        output fuinput_o,
        output fuinput_o_valid,
        input  fuinput_o_ready
    );

endinterface

// File: rtl/issue_fifo.sv
// Circular op buffer with push, pop and synchronous flush.
// Count is tracked separately so full/empty need no extra pointer bit.
module issue_fifo
    import issue_dispatch_pkg::*;
#(
    parameter int DEPTH = ISSUE_Q_DEPTH
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   push_i,
    input  logic                   pop_i,
    input  logic                   flush_i,
    input  fu_input_t              wdata_i,
    output fu_input_t              rdata_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                   full_o,
    output logic                   empty_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    fu_input_t         mem_q [DEPTH];
    logic [AW-1:0]     wr_q, wr_d;
    logic [AW-1:0]     rd_q, rd_d;
    logic [CW-1:0]     cnt_q, cnt_d;

    always_comb begin
        wr_d  = wr_q;
        rd_d  = rd_q;
        cnt_d = cnt_q;
        if (flush_i) begin
            wr_d  = '0;
            rd_d  = '0;
            cnt_d = '0;
        end else begin
            if (push_i) wr_d = wr_q + 1'b1;
            if (pop_i)  rd_d = rd_q + 1'b1;
            unique case ({push_i, pop_i})
                2'b10:   cnt_d = cnt_q + 1'b1;
                2'b01:   cnt_d = cnt_q - 1'b1;
                default: cnt_d = cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            wr_q  <= wr_d;
            rd_q  <= rd_d;
            cnt_q <= cnt_d;
        end
    end

    // Payload needs no reset: it is masked by empty on the read side.
    always_ff @(posedge clk) begin
        if (push_i && !flush_i) mem_q[wr_q] <= wdata_i;
    end

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = empty_o ? '0 : mem_q[rd_q];

endmodule

// File: rtl/issue_dispatch.sv
// In-order issue buffer between rename and the FU cluster.
// Optional perf counters: define ISSUE_DISPATCH_PERF_EN.
module issue_dispatch
    import issue_dispatch_pkg::*;
#(
    parameter int DEPTH = ISSUE_Q_DEPTH
`ifdef ISSUE_DISPATCH_PERF_EN
    ,
    parameter int CNT_W = 32
`endif
) (
    input  logic                   clk,
    input  logic                   rstn,
    issue_dispatch_if.slave        bus,
    input  logic                   squash_i,
    output logic [$clog2(DEPTH):0] occupancy_o
`ifdef ISSUE_DISPATCH_PERF_EN
    ,
    output logic [CNT_W-1:0]       perf_issued_o,
    output logic [CNT_W-1:0]       perf_stall_o,
    output logic [CNT_W-1:0]       perf_full_o
`endif
);

    logic      push, pop;
    logic      full, empty;
    fu_input_t head;

    // Ready ignores a same-cycle pop to keep ready->ready paths out.
    assign bus.op_i_ready      = !full && !squash_i;
    assign push                = bus.op_i_valid && bus.op_i_ready;
    assign bus.fuinput_o       = head;
    assign bus.fuinput_o_valid = !empty && !squash_i;
    assign pop = bus.fuinput_o_valid && bus.fuinput_o_ready[head.fu];

    issue_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rstn    (rstn),
        .push_i  (push),
        .pop_i   (pop),
        .flush_i (squash_i),
        .wdata_i (bus.op_i),
        .rdata_o (head),
        .count_o (occupancy_o),
        .full_o  (full),
        .empty_o (empty)
    );

`ifdef ISSUE_DISPATCH_PERF_EN
    logic [CNT_W-1:0] issued_q, issued_d;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic [CNT_W-1:0] fullc_q, fullc_d;

    // Saturating counters; squash deliberately leaves them alone.
    always_comb begin
        issued_d = issued_q;
        stall_d  = stall_q;
        fullc_d  = fullc_q;
        if (pop && !(&issued_q))
            issued_d = issued_q + 1'b1;
        if (bus.fuinput_o_valid && !pop && !(&stall_q))
            stall_d = stall_q + 1'b1;
        if (full && !(&fullc_q))
            fullc_d = fullc_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            issued_q <= '0;
            stall_q  <= '0;
            fullc_q  <= '0;
        end else begin
            issued_q <= issued_d;
            stall_q  <= stall_d;
            fullc_q  <= fullc_d;
        end
    end

    assign perf_issued_o = issued_q;
    assign perf_stall_o  = stall_q;
    assign perf_full_o   = fullc_q;
`endif

endmodule

// File: tb/tb_issue_dispatch.sv
// Directed bench for issue_dispatch: ordering, full, blocking, squash, reset.
// Expected values are hand-computed per step.
module tb_issue_dispatch;
    import issue_dispatch_pkg::*;

    logic       clk;
    logic       rstn;
    logic       squash_i;
    logic [2:0] occupancy_o;
    int         n_cmp;
    int         n_err;

    issue_dispatch_if bus();

`ifdef ISSUE_DISPATCH_PERF_EN
    logic [31:0] perf_issued_o;
    logic [31:0] perf_stall_o;
    logic [31:0] perf_full_o;
`endif

    issue_dispatch #(
        .DEPTH (4)
    ) dut (
        .clk         (clk),
        .rstn        (rstn),
        .bus         (bus),
        .squash_i    (squash_i),
        .occupancy_o (occupancy_o)
`ifdef ISSUE_DISPATCH_PERF_EN
        ,
        .perf_issued_o (perf_issued_o),
        .perf_stall_o  (perf_stall_o),
        .perf_full_o   (perf_full_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input fu_t fu,
                         input logic [5:0] id,
                         input fu_bitvector_t rdy, input logic sq);
        bus.op_i_valid      = v;
        bus.op_i.fu         = fu;
        bus.op_i.id         = id;
        bus.op_i.imm        = {26'h2A5A5A5, id};
        bus.fuinput_o_ready = rdy;
        squash_i            = sq;
        #1;
    endtask

    task automatic chk_head(input string tag, input logic [5:0] id);
        chk({tag, "_v"}, 64'(bus.fuinput_o_valid), 64'(1));
        chk({tag, "_id"}, 64'(bus.fuinput_o.id), 64'(id));
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rstn  = 1'b0;
        bus.op_i            = '0;
        bus.op_i_valid      = 1'b0;
        bus.fuinput_o_ready = '0;
        squash_i            = 1'b0;
        #2;
        chk("rst_rdy", 64'(bus.op_i_ready), 64'(1));
        chk("rst_val", 64'(bus.fuinput_o_valid), 64'(0));
        chk("rst_head", 64'(bus.fuinput_o), 64'(0));
        chk("rst_occ", 64'(occupancy_o), 64'(0));
        #10 rstn = 1'b1;
        tick();

        // in-order issue, ALU always ready
        drive(1, FU_ALU, 6'd1, 4'b0001, 0);
        chk("t1_empty", 64'(bus.fuinput_o_valid), 64'(0));
        tick();
        drive(1, FU_ALU, 6'd2, 4'b0001, 0);
        chk_head("t1_h1", 6'd1);
        tick();
        drive(1, FU_ALU, 6'd3, 4'b0001, 0);
        chk_head("t1_h2", 6'd2);
        chk("t1_occ2", 64'(occupancy_o), 64'(1));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0001, 0);
        chk_head("t1_h3", 6'd3);
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0001, 0);
        chk("t1_done_v", 64'(bus.fuinput_o_valid), 64'(0));
        chk("t1_done_occ", 64'(occupancy_o), 64'(0));
        tick();

        // fill to full, then drain
        for (int i = 0; i < 4; i++) begin
            drive(1, FU_ALU, 6'(10 + i), 4'b0000, 0);
            chk("t2_fill_rdy", 64'(bus.op_i_ready), 64'(1));
            tick();
        end
        drive(1, FU_ALU, 6'd14, 4'b0000, 0);
        chk("t2_full_rdy", 64'(bus.op_i_ready), 64'(0));
        chk("t2_full_occ", 64'(occupancy_o), 64'(4));
        chk_head("t2_full_h", 6'd10);
        tick();
        drive(1, FU_ALU, 6'd14, 4'b0001, 0);
        chk("t2_pop_rdy", 64'(bus.op_i_ready), 64'(0));
        chk_head("t2_pop_h", 6'd10);
        tick();
        drive(1, FU_ALU, 6'd14, 4'b0001, 0);
        chk("t2_after_rdy", 64'(bus.op_i_ready), 64'(1));
        chk("t2_after_occ", 64'(occupancy_o), 64'(3));
        chk_head("t2_h11", 6'd11);
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0001, 0);
        chk_head("t2_h12", 6'd12);
        chk("t2_occ_pp", 64'(occupancy_o), 64'(3));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0001, 0);
        chk_head("t2_h13", 6'd13);
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0001, 0);
        chk_head("t2_h14", 6'd14);
        chk("t2_occ1", 64'(occupancy_o), 64'(1));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0001, 0);
        chk("t2_empty_occ", 64'(occupancy_o), 64'(0));
        tick();

        // blocked head on MUL holds back a ready ALU op
        drive(1, FU_MUL, 6'd20, 4'b0001, 0);
        tick();
        drive(1, FU_ALU, 6'd21, 4'b0001, 0);
        chk_head("t3_h20", 6'd20);
        tick();
        for (int i = 0; i < 10; i++) begin
            drive(0, FU_ALU, 6'd0, 4'b0001, 0);
            chk_head("t3_block", 6'd20);
            chk("t3_block_occ", 64'(occupancy_o), 64'(2));
            tick();
        end
        drive(0, FU_ALU, 6'd0, 4'b0011, 0);
        chk("t3_fu_mul", 64'(bus.fuinput_o.fu), 64'(FU_MUL));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0011, 0);
        chk_head("t3_h21", 6'd21);
        chk("t3_fu_alu", 64'(bus.fuinput_o.fu), 64'(FU_ALU));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0000, 0);
        chk("t3_empty", 64'(occupancy_o), 64'(0));
        tick();

        // simultaneous push and pop at count 1
        drive(1, FU_ALU, 6'd6, 4'b0000, 0);
        tick();
        drive(1, FU_ALU, 6'd7, 4'b0001, 0);
        chk_head("t4_h6", 6'd6);
        chk("t4_rdy", 64'(bus.op_i_ready), 64'(1));
        chk("t4_occ_a", 64'(occupancy_o), 64'(1));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0000, 0);
        chk_head("t4_h7", 6'd7);
        chk("t4_occ_b", 64'(occupancy_o), 64'(1));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0001, 0);
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0000, 0);
        chk("t4_empty", 64'(occupancy_o), 64'(0));
        tick();

        // squash with 3 buffered and a pending push
        for (int i = 0; i < 3; i++) begin
            drive(1, FU_ALU, 6'(30 + i), 4'b0000, 0);
            tick();
        end
        drive(1, FU_ALU, 6'd33, 4'b1111, 1);
        chk("t5_sq_rdy", 64'(bus.op_i_ready), 64'(0));
        chk("t5_sq_v", 64'(bus.fuinput_o_valid), 64'(0));
        chk("t5_sq_occ", 64'(occupancy_o), 64'(3));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b1111, 1);
        chk("t5_sq2_occ", 64'(occupancy_o), 64'(0));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b1111, 0);
        chk("t5_post_occ", 64'(occupancy_o), 64'(0));
        chk("t5_post_v", 64'(bus.fuinput_o_valid), 64'(0));
        chk("t5_post_head", 64'(bus.fuinput_o), 64'(0));
        tick();
        drive(1, FU_ALU, 6'd40, 4'b0000, 0);
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0000, 0);
        chk_head("t5_h40", 6'd40);
        chk("t5_occ1", 64'(occupancy_o), 64'(1));
        tick();

        // asynchronous reset mid-operation
        drive(1, FU_ALU, 6'd41, 4'b0000, 0);
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0000, 0);
        chk("t6_pre_occ", 64'(occupancy_o), 64'(2));
        #2 rstn = 1'b0;
        #1;
        chk("t6_rst_occ", 64'(occupancy_o), 64'(0));
        chk("t6_rst_v", 64'(bus.fuinput_o_valid), 64'(0));
        chk("t6_rst_rdy", 64'(bus.op_i_ready), 64'(1));
        #2 rstn = 1'b1;
        tick();

`ifdef ISSUE_DISPATCH_PERF_EN
        chk("p_rst_iss", 64'(perf_issued_o), 64'(0));
        chk("p_rst_stl", 64'(perf_stall_o), 64'(0));
        drive(1, FU_ALU, 6'd50, 4'b0000, 0);
        tick();
        drive(1, FU_ALU, 6'd51, 4'b0000, 0);
        tick();
        for (int i = 0; i < 4; i++) begin
            drive(0, FU_ALU, 6'd0, 4'b0000, 0);
            tick();
        end
        drive(0, FU_ALU, 6'd0, 4'b0001, 0);
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0001, 0);
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0000, 0);
        chk("p_iss", 64'(perf_issued_o), 64'(2));
        chk("p_stl", 64'(perf_stall_o), 64'(5));
        chk("p_full", 64'(perf_full_o), 64'(0));
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0000, 1);
        tick();
        drive(0, FU_ALU, 6'd0, 4'b0000, 0);
        chk("p_sq_iss", 64'(perf_issued_o), 64'(2));
        chk("p_sq_stl", 64'(perf_stall_o), 64'(5));
        tick();
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule
